// File: rtl/id_fwd_stage_if.sv
// ---------------------------------------------------------------------------
// id_fwd_stage_if
// Bundle of every non-clock signal of the decode-to-execute operand stage.
//   in_*      : decoded instruction from ID (valid/ready handshake)
//   rf_*      : combinational register-file read data for in_rs1/in_rs2
//   fwd_*     : NFWD packed forwarding sources, index 0 = youngest
//   flush     : kill held and incoming instruction
//   out_*     : ID/EX pipeline register towards EX (valid/ready handshake)
// Modports:
//   master : the ID side / environment (drives instruction, fwd, out_ready)
//   slave  : the operand stage itself
// ---------------------------------------------------------------------------
interface id_fwd_stage_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int NFWD  = 2,
    parameter int OPW   = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [OPW-1:0]        in_op;
    logic [RADDR-1:0]      in_rs1;
    logic [RADDR-1:0]      in_rs2;
    logic                  in_rs1_used;
    logic                  in_rs2_used;
    logic [RADDR-1:0]      in_rd;
    logic                  in_we;
    logic                  in_is_load;
    logic [XLEN-1:0]       in_imm;
    logic                  in_b_imm;
    logic [XLEN-1:0]       rf_rdata1;
    logic [XLEN-1:0]       rf_rdata2;
    logic [NFWD-1:0]       fwd_we;
    logic [NFWD*RADDR-1:0] fwd_addr;
    logic [NFWD*XLEN-1:0]  fwd_data;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [OPW-1:0]        out_op;
    logic [XLEN-1:0]       out_a;
    logic [XLEN-1:0]       out_b;
    logic [RADDR-1:0]      out_rd;
    logic                  out_we;
    logic                  out_is_load;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rs1_used, in_rs2_used,
               in_rd, in_we, in_is_load, in_imm, in_b_imm,
               rf_rdata1, rf_rdata2, fwd_we, fwd_addr, fwd_data,
               flush, out_ready,
        input  in_ready, out_valid, out_op, out_a, out_b, out_rd,
               out_we, out_is_load
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rs1_used, in_rs2_used,
               in_rd, in_we, in_is_load, in_imm, in_b_imm,
               rf_rdata1, rf_rdata2, fwd_we, fwd_addr, fwd_data,
               flush, out_ready,
        output in_ready, out_valid, out_op, out_a, out_b, out_rd,
               out_we, out_is_load
    );
endinterface

// File: rtl/id_fwd_stage.sv
// ---------------------------------------------------------------------------
// id_fwd_stage
// RV32I decode-to-execute operand stage. Resolves operands A/B with N-way
// priority forwarding and x0 masking, detects load-use hazards (inserting
// LOAD_LAT bubbles) and owns the ID/EX register with valid/ready on both
// sides plus a synchronous flush.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : id_fwd_stage_if.slave (instruction in, forwarding, flush, EX out)
// ---------------------------------------------------------------------------
module id_fwd_stage #(
    parameter int XLEN     = 32,
    parameter int RADDR    = 5,
    parameter int NFWD     = 2,
    parameter int LOAD_LAT = 1,
    parameter int OPW      = 8
) (
    input  logic             clk,
    input  logic             rst,
    id_fwd_stage_if.slave    bus
);
    // A load leaving the register already accounts for one bubble; the
    // counter covers the remaining LOAD_LAT-1 cycles.
    localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);

    logic [NFWD-1:0]  hit1;
    logic [NFWD-1:0]  hit2;
    logic [XLEN-1:0]  src1_val;
    logic [XLEN-1:0]  src2_val;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic             rs1_rd;
    logic             rs2_rd;
    logic             dep_out;
    logic             dep_pend;
    logic             haz;
    logic             advance;
    logic             load_leaving;

    logic             out_valid_reg;
    logic [OPW-1:0]   out_op_reg;
    logic [XLEN-1:0]  out_a_reg;
    logic [XLEN-1:0]  out_b_reg;
    logic [RADDR-1:0] out_rd_reg;
    logic             out_we_reg;
    logic             out_is_load_reg;
    logic [2:0]       cnt_reg;
    logic [RADDR-1:0] pend_rd_reg;

    // Per-source match; a source writing x0 never forwards.
    genvar gi;
    generate
        for (gi = 0; gi < NFWD; gi++) begin : g_hit
            logic [RADDR-1:0] src_addr;
            assign src_addr  = bus.fwd_addr[gi*RADDR +: RADDR];
            assign hit1[gi]  = bus.fwd_we[gi] && (src_addr == bus.in_rs1) && (src_addr != '0);
            assign hit2[gi]  = bus.fwd_we[gi] && (src_addr == bus.in_rs2) && (src_addr != '0);
        end
    endgenerate

    // Scan from the oldest source down so the youngest hit is the last write.
    always_comb begin
        src1_val = bus.rf_rdata1;
        src2_val = bus.rf_rdata2;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (hit1[i]) src1_val = bus.fwd_data[i*XLEN +: XLEN];
            if (hit2[i]) src2_val = bus.fwd_data[i*XLEN +: XLEN];
        end
    end

    assign op_a = (bus.in_rs1_used && (bus.in_rs1 != '0)) ? src1_val : '0;
    assign op_b = bus.in_b_imm ? bus.in_imm :
                  ((bus.in_rs2_used && (bus.in_rs2 != '0)) ? src2_val : '0);

    // rs2 only creates a dependency when it actually feeds operand B.
    assign rs1_rd   = bus.in_rs1_used;
    assign rs2_rd   = bus.in_rs2_used && !bus.in_b_imm;
    assign dep_out  = (out_rd_reg != '0) &&
                      ((rs1_rd && (bus.in_rs1 == out_rd_reg)) ||
                       (rs2_rd && (bus.in_rs2 == out_rd_reg)));
    assign dep_pend = (pend_rd_reg != '0) &&
                      ((rs1_rd && (bus.in_rs1 == pend_rd_reg)) ||
                       (rs2_rd && (bus.in_rs2 == pend_rd_reg)));

    assign haz = (out_valid_reg && out_is_load_reg && out_we_reg && dep_out) ||
                 ((cnt_reg != 3'd0) && dep_pend);

    assign advance      = !out_valid_reg || bus.out_ready;
    assign load_leaving = advance && out_valid_reg && out_is_load_reg &&
                          out_we_reg && (out_rd_reg != '0);

    assign bus.in_ready = advance && !haz && !bus.flush;

    // ID/EX register. Bubbles and flushes zero the payload as well.
    always_ff @(posedge clk) begin
        if (rst || bus.flush || (advance && !(bus.in_valid && !haz))) begin
            out_valid_reg   <= 1'b0;
            out_op_reg      <= '0;
            out_a_reg       <= '0;
            out_b_reg       <= '0;
            out_rd_reg      <= '0;
            out_we_reg      <= 1'b0;
            out_is_load_reg <= 1'b0;
        end else if (advance) begin
            out_valid_reg   <= 1'b1;
            out_op_reg      <= bus.in_op;
            out_a_reg       <= op_a;
            out_b_reg       <= op_b;
            out_rd_reg      <= bus.in_rd;
            out_we_reg      <= bus.in_we;
            out_is_load_reg <= bus.in_is_load;
        end
    end

    // Load-use stall counter; frozen whenever EX back-pressures.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= 3'd0;
            pend_rd_reg <= '0;
        end else if (bus.flush) begin
            cnt_reg     <= 3'd0;
        end else if (load_leaving) begin
            cnt_reg     <= CNT_INIT;
            pend_rd_reg <= out_rd_reg;
        end else if ((cnt_reg != 3'd0) && advance) begin
            cnt_reg     <= cnt_reg - 3'd1;
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.out_op      = out_op_reg;
    assign bus.out_a       = out_a_reg;
    assign bus.out_b       = out_b_reg;
    assign bus.out_rd      = out_rd_reg;
    assign bus.out_we      = out_we_reg;
    assign bus.out_is_load = out_is_load_reg;
endmodule

// File: tb/tb_id_fwd_stage.sv
// ---------------------------------------------------------------------------
// tb_id_fwd_stage
// Two instances share one stimulus driver: dut1 with LOAD_LAT=1, dut2 with
// LOAD_LAT=2; sel routes in_valid to one of them and muxes its outputs to
// the monitor. Expected transfers are queued at issue time and popped by an
// independent monitor whenever out_valid & out_ready.
// ---------------------------------------------------------------------------
module tb_id_fwd_stage;
    localparam int XLEN = 32, RADDR = 5, NFWD = 2, OPW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_fwd_stage_if #(.XLEN(XLEN), .RADDR(RADDR), .NFWD(NFWD), .OPW(OPW)) bus1();
    id_fwd_stage_if #(.XLEN(XLEN), .RADDR(RADDR), .NFWD(NFWD), .OPW(OPW)) bus2();

    id_fwd_stage #(.XLEN(XLEN), .RADDR(RADDR), .NFWD(NFWD), .LOAD_LAT(1), .OPW(OPW))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    id_fwd_stage #(.XLEN(XLEN), .RADDR(RADDR), .NFWD(NFWD), .LOAD_LAT(2), .OPW(OPW))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic                  sel;
    logic                  drv_valid, drv_u1, drv_u2, drv_we, drv_ld, drv_bimm;
    logic                  drv_flush, drv_oready;
    logic [OPW-1:0]        drv_op;
    logic [RADDR-1:0]      drv_rs1, drv_rs2, drv_rd;
    logic [XLEN-1:0]       drv_imm, drv_rf1, drv_rf2;
    logic [NFWD-1:0]       drv_fwe;
    logic [NFWD*RADDR-1:0] drv_faddr;
    logic [NFWD*XLEN-1:0]  drv_fdata;

    assign bus1.in_valid = drv_valid & ~sel;
    assign bus2.in_valid = drv_valid & sel;
    assign bus1.in_op = drv_op;          assign bus2.in_op = drv_op;
    assign bus1.in_rs1 = drv_rs1;        assign bus2.in_rs1 = drv_rs1;
    assign bus1.in_rs2 = drv_rs2;        assign bus2.in_rs2 = drv_rs2;
    assign bus1.in_rs1_used = drv_u1;    assign bus2.in_rs1_used = drv_u1;
    assign bus1.in_rs2_used = drv_u2;    assign bus2.in_rs2_used = drv_u2;
    assign bus1.in_rd = drv_rd;          assign bus2.in_rd = drv_rd;
    assign bus1.in_we = drv_we;          assign bus2.in_we = drv_we;
    assign bus1.in_is_load = drv_ld;     assign bus2.in_is_load = drv_ld;
    assign bus1.in_imm = drv_imm;        assign bus2.in_imm = drv_imm;
    assign bus1.in_b_imm = drv_bimm;     assign bus2.in_b_imm = drv_bimm;
    assign bus1.rf_rdata1 = drv_rf1;     assign bus2.rf_rdata1 = drv_rf1;
    assign bus1.rf_rdata2 = drv_rf2;     assign bus2.rf_rdata2 = drv_rf2;
    assign bus1.fwd_we = drv_fwe;        assign bus2.fwd_we = drv_fwe;
    assign bus1.fwd_addr = drv_faddr;    assign bus2.fwd_addr = drv_faddr;
    assign bus1.fwd_data = drv_fdata;    assign bus2.fwd_data = drv_fdata;
    assign bus1.flush = drv_flush;       assign bus2.flush = drv_flush;
    assign bus1.out_ready = drv_oready;  assign bus2.out_ready = drv_oready;

    logic            mon_valid, mon_in_ready, mon_we, mon_ld;
    logic [OPW-1:0]  mon_op;
    logic [XLEN-1:0] mon_a, mon_b;
    logic [RADDR-1:0] mon_rd;
    assign mon_valid    = sel ? bus2.out_valid   : bus1.out_valid;
    assign mon_in_ready = sel ? bus2.in_ready    : bus1.in_ready;
    assign mon_op       = sel ? bus2.out_op      : bus1.out_op;
    assign mon_a        = sel ? bus2.out_a       : bus1.out_a;
    assign mon_b        = sel ? bus2.out_b       : bus1.out_b;
    assign mon_rd       = sel ? bus2.out_rd      : bus1.out_rd;
    assign mon_we       = sel ? bus2.out_we      : bus1.out_we;
    assign mon_ld       = sel ? bus2.out_is_load : bus1.out_is_load;

    typedef struct {
        logic [OPW-1:0]   op;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [RADDR-1:0] rd;
        logic             we;
        logic             ld;
        int               gap;   // idle cycles since previous transfer, -1 = any
        string            nm;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_cyc = -100;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one transfer per cycle in which out_valid & out_ready.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && mon_valid && drv_oready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got op=%h a=%h with no transfer expected", mon_op, mon_a);
            end else begin
                e = sb.pop_front();
                chk({e.nm, "_op"}, 32'(mon_op), 32'(e.op));
                chk({e.nm, "_a"},  mon_a, e.a);
                chk({e.nm, "_b"},  mon_b, e.b);
                chk({e.nm, "_rd"}, 32'(mon_rd), 32'(e.rd));
                chk({e.nm, "_we_ld"}, {30'd0, mon_we, mon_ld}, {30'd0, e.we, e.ld});
                if (e.gap >= 0) chk({e.nm, "_gap"}, 32'(cyc - last_cyc - 1), 32'(e.gap));
            end
            last_cyc <= cyc;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after acceptance.
    task automatic send(input logic [7:0] op, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic bimm,
                        input logic [31:0] imm, input logic [4:0] rd, input logic we,
                        input logic ld, input logic [31:0] ea, input logic [31:0] eb,
                        input int ewait, input int egap, input logic push, input string nm);
        int   waits;
        exp_t e;
        waits = 0;
        drv_op = op; drv_rs1 = rs1; drv_u1 = u1; drv_rs2 = rs2; drv_u2 = u2;
        drv_bimm = bimm; drv_imm = imm; drv_rd = rd; drv_we = we; drv_ld = ld;
        drv_valid = 1'b1;
        if (push) begin
            e.op = op; e.a = ea; e.b = eb; e.rd = rd; e.we = we; e.ld = ld;
            e.gap = egap; e.nm = nm;
            sb.push_back(e);
        end
        #1;
        while (!mon_in_ready && waits < 50) begin
            @(posedge clk);
            #2;
            waits++;
        end
        chk({nm, "_stall"}, 32'(waits), 32'(ewait));
        if (mon_in_ready) begin
            @(posedge clk);
            #1;
        end else begin
            drv_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        drv_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; rst = 1'b1;
        drv_valid = 0; drv_u1 = 0; drv_u2 = 0; drv_we = 0; drv_ld = 0; drv_bimm = 0;
        drv_flush = 0; drv_oready = 1; drv_op = '0; drv_rs1 = '0; drv_rs2 = '0;
        drv_rd = '0; drv_imm = '0; drv_rf1 = '0; drv_rf2 = '0;
        drv_fwe = '0; drv_faddr = '0; drv_fdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_valid1", 32'(bus1.out_valid), 32'd0);
        chk("rst_a1",     bus1.out_a, 32'd0);
        chk("rst_b1",     bus1.out_b, 32'd0);
        chk("rst_rdy1",   32'(bus1.in_ready), 32'd1);
        chk("rst_valid2", 32'(bus2.out_valid), 32'd0);
        chk("rst_rdy2",   32'(bus2.in_ready), 32'd1);
        @(posedge clk); #1;

        // Forwarding priority, single source, regfile fallback.
        drv_fwe = 2'b11; drv_faddr = {5'd5, 5'd5};
        drv_fdata = {32'h11111111, 32'hAAAA0000};
        drv_rf1 = 32'h0; drv_rf2 = 32'h22;
        send(8'h01, 5'd5, 1, 5'd6, 1, 0, 32'h0, 5'd7, 1, 0, 32'hAAAA0000, 32'h22, 0, -1, 1, "t1_prio");
        drv_fwe = 2'b10; drv_rf1 = 32'h55;
        send(8'h02, 5'd5, 1, 5'd6, 1, 0, 32'h0, 5'd8, 1, 0, 32'h11111111, 32'h22, 0, 0, 1, "t1_src1");
        drv_fwe = 2'b00;
        send(8'h03, 5'd5, 1, 5'd6, 1, 0, 32'h0, 5'd8, 1, 0, 32'h55, 32'h22, 0, 0, 1, "t1_rf");

        // x0 masking, unused source, immediate operand.
        drv_fwe = 2'b01; drv_faddr = {5'd0, 5'd0};
        drv_fdata = {32'h0, 32'hDEADBEEF};
        drv_rf1 = 32'hFFFFFFFF; drv_rf2 = 32'hFFFFFFFF;
        send(8'h04, 5'd0, 1, 5'd0, 1, 0, 32'h0, 5'd9, 1, 0, 32'h0, 32'h0, 0, 0, 1, "t2_x0");
        drv_faddr = {5'd0, 5'd9};
        send(8'h05, 5'd9, 0, 5'd9, 1, 1, 32'hFFFFF800, 5'd10, 1, 0, 32'h0, 32'hFFFFF800, 0, 0, 1, "t2_imm");
        idle(3);

        // Load-use with LOAD_LAT=1: one bubble.
        drv_fwe = 2'b00; drv_rf1 = 32'h1000;
        send(8'h10, 5'd2, 1, 5'd0, 0, 1, 32'h4, 5'd3, 1, 1, 32'h1000, 32'h4, 0, -1, 1, "t3_lw");
        drv_fwe = 2'b01; drv_faddr = {5'd0, 5'd3}; drv_fdata = {32'h0, 32'hCAFEF00D};
        drv_rf1 = 32'hBAD; drv_rf2 = 32'hBAD;
        send(8'h01, 5'd3, 1, 5'd3, 1, 0, 32'h0, 5'd4, 1, 0, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1, 1, "t3_add");
        idle(3);

        // LOAD_LAT=2: two bubbles; independent and x0-load followers do not stall.
        sel = 1'b1;
        drv_fwe = 2'b00; drv_rf1 = 32'h2000;
        send(8'h10, 5'd2, 1, 5'd0, 0, 1, 32'h4, 5'd3, 1, 1, 32'h2000, 32'h4, 0, -1, 1, "t4_lw");
        drv_fwe = 2'b01; drv_faddr = {5'd0, 5'd3}; drv_fdata = {32'h0, 32'h12340000};
        drv_rf1 = 32'hBAD; drv_rf2 = 32'hBAD;
        send(8'h01, 5'd3, 1, 5'd3, 1, 0, 32'h0, 5'd4, 1, 0, 32'h12340000, 32'h12340000, 2, 2, 1, "t4_add");
        drv_fwe = 2'b00; drv_rf1 = 32'h3000;
        send(8'h10, 5'd2, 1, 5'd0, 0, 1, 32'h4, 5'd3, 1, 1, 32'h3000, 32'h4, 0, 0, 1, "t4_lw2");
        drv_rf1 = 32'h77;
        send(8'h11, 5'd7, 1, 5'd0, 0, 1, 32'h10, 5'd8, 1, 0, 32'h77, 32'h10, 0, 0, 1, "t4_addi");
        drv_rf1 = 32'h3300;
        send(8'h10, 5'd2, 1, 5'd0, 0, 1, 32'h8, 5'd0, 1, 1, 32'h3300, 32'h8, 0, 0, 1, "t4_lw_x0");
        send(8'h01, 5'd0, 1, 5'd0, 1, 0, 32'h0, 5'd5, 1, 0, 32'h0, 32'h0, 0, 0, 1, "t4_use_x0");
        idle(3);

        // Backpressure: held payload, forwarding changes ignored.
        sel = 1'b0;
        drv_fwe = 2'b01; drv_faddr = {5'd0, 5'd5}; drv_fdata = {32'h0, 32'h0A0A0A0A};
        send(8'h20, 5'd5, 1, 5'd0, 0, 1, 32'h1, 5'd11, 1, 0, 32'h0A0A0A0A, 32'h1, 0, -1, 1, "t5_a");
        drv_oready = 1'b0;
        begin : t5_b
            exp_t e;
            drv_op = 8'h21; drv_rs1 = 5'd12; drv_u1 = 1; drv_rs2 = 5'd13; drv_u2 = 1;
            drv_bimm = 0; drv_rf1 = 32'h1212; drv_rf2 = 32'h1313; drv_rd = 5'd14;
            drv_we = 1; drv_ld = 0; drv_valid = 1'b1;
            e.op = 8'h21; e.a = 32'h1212; e.b = 32'h1313; e.rd = 5'd14; e.we = 1; e.ld = 0;
            e.gap = 0; e.nm = "t5_b";
            sb.push_back(e);
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_hold_rdy",   32'(mon_in_ready), 32'd0);
            chk("t5_hold_valid", 32'(mon_valid), 32'd1);
            chk("t5_hold_a",     mon_a, 32'h0A0A0A0A);
            chk("t5_hold_b",     mon_b, 32'h1);
            drv_fdata = {32'h0, 32'hF0F0F0F0 ^ 32'(k)};
            @(posedge clk); #1;
        end
        drv_oready = 1'b1;
        #1 chk("t5_release_rdy", 32'(mon_in_ready), 32'd1);
        @(posedge clk); #1;
        idle(3);

        // Flush during load-use stall under backpressure: flush wins.
        sel = 1'b1;
        drv_oready = 1'b0; drv_fwe = 2'b00; drv_rf1 = 32'h4000;
        send(8'h10, 5'd2, 1, 5'd0, 0, 1, 32'h4, 5'd3, 1, 1, 32'h0, 32'h0, 0, -1, 0, "t6_lw");
        drv_op = 8'h01; drv_rs1 = 5'd3; drv_rs2 = 5'd3; drv_u1 = 1; drv_u2 = 1;
        drv_bimm = 0; drv_rd = 5'd4; drv_we = 1; drv_ld = 0; drv_rf1 = 32'h5; drv_rf2 = 32'h5;
        #1 chk("t6_stall_rdy", 32'(mon_in_ready), 32'd0);
        drv_flush = 1'b1;
        #1 chk("t6_flush_rdy", 32'(mon_in_ready), 32'd0);
        @(posedge clk); #1;
        drv_flush = 1'b0; drv_oready = 1'b1;
        chk("t6_killed", 32'(mon_valid), 32'd0);
        send(8'h01, 5'd3, 1, 5'd3, 1, 0, 32'h0, 5'd4, 1, 0, 32'h5, 32'h5, 0, -1, 1, "t6_after");
        idle(3);

        // Reset while a load-use stall is pending.
        drv_oready = 1'b0; drv_rf1 = 32'h4400;
        send(8'h10, 5'd2, 1, 5'd0, 0, 1, 32'h4, 5'd3, 1, 1, 32'h0, 32'h0, 0, -1, 0, "t7_lw");
        drv_op = 8'h02; drv_rs1 = 5'd3; drv_rs2 = 5'd3; drv_u1 = 1; drv_u2 = 1;
        drv_bimm = 0; drv_rd = 5'd6; drv_we = 1; drv_ld = 0; drv_rf1 = 32'h9; drv_rf2 = 32'h8;
        #1 chk("t7_stall_rdy", 32'(mon_in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; drv_oready = 1'b1;
        chk("t7_rst_valid", 32'(mon_valid), 32'd0);
        send(8'h02, 5'd3, 1, 5'd3, 1, 0, 32'h0, 5'd6, 1, 0, 32'h9, 32'h8, 0, -1, 1, "t7_after");
        idle(5);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
